// File: rtl/core_seq_ctrl_if.sv
// Control/strobe bundle between the sequencing controller and the core datapath.
// The datapath side (master) drives decoded controls and run; the controller (slave) drives strobes.
interface core_seq_ctrl_if;
  logic run;
  logic reg_write;
  logic mem_read;
  logic mem_write;
  logic imem_en;
  logic dmem_en;
  logic dmem_we;
  logic pc_en;
  logic rf_we;

  modport master (
    output run, reg_write, mem_read, mem_write,
    input  imem_en, dmem_en, dmem_we, pc_en, rf_we
  );

  modport slave (
    input  run, reg_write, mem_read, mem_write,
    output imem_en, dmem_en, dmem_we, pc_en, rf_we
  );
endinterface

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer: FETCH -> EXEC -> (MEM) -> WB, waiting out memory latencies and
// emitting PC-advance / register-write strobes only once the memory outputs are valid.
module core_seq_ctrl #(
  parameter int IMEM_LAT = 2,
  parameter int DMEM_LAT = 2,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  core_seq_ctrl_if.slave     bus,
  output logic               busy,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   retired
);

  localparam int MAX_LAT = (IMEM_LAT > DMEM_LAT) ? IMEM_LAT : DMEM_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wb_q, wb_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic imem_en, dmem_en, dmem_we, pc_en, rf_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wb_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_q      <= wb_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic; outputs depend only on registered state and the latched controls.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wb_d      = wb_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    retired_d = retired_q;
    imem_en   = 1'b0;
    dmem_en   = 1'b0;
    dmem_we   = 1'b0;
    pc_en     = 1'b0;
    rf_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_FETCH;
          cnt_d   = CW'(IMEM_LAT - 1);
        end
      end
      S_FETCH: begin
        imem_en = 1'b1;
        if (cnt_q == '0) state_d = S_EXEC;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_EXEC: begin
        imem_en = 1'b1;
        wb_d    = bus.reg_write;
        rd_d    = bus.mem_read;
        wr_d    = bus.mem_write;
        if (bus.mem_read || bus.mem_write) begin
          state_d = S_MEM;
          cnt_d   = CW'(DMEM_LAT - 1);
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // Read+write together is treated as a write: dmem_we follows wr_q alone.
        dmem_en = 1'b1;
        dmem_we = wr_q;
        if (cnt_q == '0) state_d = S_WB;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_WB: begin
        pc_en     = 1'b1;
        rf_we     = wb_q;
        retired_d = retired_q + CNT_W'(1);
        if (bus.run) begin
          state_d = S_FETCH;
          cnt_d   = CW'(IMEM_LAT - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.imem_en = imem_en;
  assign bus.dmem_en = dmem_en;
  assign bus.dmem_we = dmem_we;
  assign bus.pc_en   = pc_en;
  assign bus.rf_we   = rf_we;
  assign busy        = (state_q != S_IDLE);
  assign state       = state_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl (default latencies, 4-bit retired counter to exercise wrap).
module tb_core_seq_ctrl;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             busy;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  core_seq_ctrl_if bus ();

  core_seq_ctrl #(.IMEM_LAT(2), .DMEM_LAT(2), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .busy    (busy),
    .state   (state),
    .retired (retired)
  );

  // Expected record per instruction: {retired[3:0], rf_we, dmem_we_seen, dmem_cycles[3:0], imem_cycles[3:0], span[3:0]}
  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_ret = '0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [17:0] rec(input logic [3:0] ret, input logic rf, input logic we,
                                      input logic [3:0] dm, input logic [3:0] span);
    return {ret, rf, we, dm, 4'd3, span};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [2:0] prev_state = '0;
  logic [3:0] m_cyc, m_dm, m_im;
  logic       m_we;
  logic [17:0] got, exp_r;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_state = '0;
    end else begin
      if (state == 3'd1 && prev_state != 3'd1) begin
        m_cyc = '0; m_dm = '0; m_im = '0; m_we = 1'b0;
      end
      if (busy)        m_cyc++;
      if (bus.dmem_en) m_dm++;
      if (bus.imem_en) m_im++;
      if (bus.dmem_we) m_we = 1'b1;
      if (bus.rf_we) check("rf_we_with_pc_en", {31'd0, bus.pc_en}, 32'd1);
      if (bus.pc_en) begin
        // retired already counts this instruction one edge after WB; compare the post-edge value at next sample
        got = {retired + 4'd1, bus.rf_we, m_we, m_dm, m_im, m_cyc};
        if (exp_q.size() == 0) begin
          check("unexpected_pc_en", 32'd1, 32'd0);
        end else begin
          exp_r = exp_q.pop_front();
          check("instr_record", {14'd0, got}, {14'd0, exp_r});
        end
      end
      prev_state = state;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ctrl(input logic rw, input logic mr, input logic mw);
    bus.reg_write = rw;
    bus.mem_read  = mr;
    bus.mem_write = mw;
  endtask

  task automatic wait_pc_en();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.pc_en && n < 50);
    if (!bus.pc_en) check("pc_en_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n = 0;
    while (state != s && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (state != s) check("state_timeout", {29'd0, state}, {29'd0, s});
  endtask

  // Issue one instruction; expected response computed by hand from the latency table.
  task automatic issue(input logic rw, input logic mr, input logic mw);
    logic mem;
    mem = mr | mw;
    set_ctrl(rw, mr, mw);
    exp_ret = exp_ret + 4'd1;
    exp_q.push_back(rec(exp_ret, rw, mw, mem ? 4'd2 : 4'd0, mem ? 4'd6 : 4'd4));
    wait_pc_en();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"},   {29'd0, state}, 32'd0);
    check({tag, "_busy"},    {31'd0, busy}, 32'd0);
    check({tag, "_strobes"}, {27'd0, bus.imem_en, bus.dmem_en, bus.dmem_we, bus.pc_en, bus.rf_we}, 32'd0);
    check({tag, "_retired"}, {28'd0, retired}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.run = 1'b1;
    set_ctrl(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");

    rst_n = 1'b1;
    @(negedge clk);
    check("release_fetch", {29'd0, state}, 32'd1);

    // ALU stream: retired 1..3, 4-cycle pc_en period
    for (int i = 0; i < 3; i++) issue(1'b1, 1'b0, 1'b0);
    // load, store, read+write (treated as store)
    issue(1'b1, 1'b1, 1'b0);
    issue(1'b0, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 1'b1);

    // Pause: drop run during MEM; instruction still completes, then IDLE
    set_ctrl(1'b1, 1'b1, 1'b0);
    exp_ret = exp_ret + 4'd1;
    exp_q.push_back(rec(exp_ret, 1'b1, 1'b0, 4'd2, 4'd6));
    wait_state(3'd3);
    bus.run = 1'b0;
    wait_pc_en();
    @(negedge clk);
    check("pause_idle_state", {29'd0, state}, 32'd0);
    check("pause_idle_busy", {31'd0, busy}, 32'd0);
    check("pause_retired", {28'd0, retired}, 32'd7);
    bus.run = 1'b1;
    @(negedge clk);
    check("resume_fetch", {29'd0, state}, 32'd1);
    issue(1'b1, 1'b0, 1'b0);

    // Abort mid-MEM: outputs drop immediately, nothing retires
    set_ctrl(1'b1, 1'b1, 1'b0);
    wait_state(3'd3);
    check("abort_pre_dmem_en", {31'd0, bus.dmem_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ret = '0;
    @(negedge clk);
    check("abort_release_fetch", {29'd0, state}, 32'd1);

    // Wrap: 17 ALU instructions on a 4-bit counter end at 1
    for (int i = 0; i < 17; i++) issue(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("wrap_retired", {28'd0, retired}, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
